gpio_port: RTL and testbench

GPIO_PORT -- requirements
Module: gpio_port

---
 rtl/gpio_port.sv | 180 ++++++++++++++++++
 tb/tb_gpio_port.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_port.sv
// Memory-mapped GPIO port: MODE/IDATA/ODATA/INTCFG registers and two edge-interrupt channels.
// Define GPIO_PORT_SYNC_EN to insert a 2-FF input synchroniser; otherwise one input register.
module gpio_port #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wr_data,
  input  logic [3:0]            wr_strobe,
  output logic [31:0]           rd_data,
  input  logic [WIDTH-1:0]      gpio_i,
  output logic [WIDTH-1:0]      gpio_o,
  output logic [WIDTH-1:0]      gpio_oe,
  output logic                  int0,
  output logic                  int1
);

  localparam logic [1:0] REG_MODE   = 2'd0;
  localparam logic [1:0] REG_IDATA  = 2'd1;
  localparam logic [1:0] REG_ODATA  = 2'd2;
  localparam logic [1:0] REG_INTCFG = 2'd3;

  logic [WIDTH-1:0] mode_q,  mode_d;
  logic [WIDTH-1:0] odata_q, odata_d;
  logic [WIDTH-1:0] sync_q,  sync_d;
  logic [WIDTH-1:0] dly_q,   dly_d;
  logic [4:0]       sel0_q,  sel0_d,  sel1_q,  sel1_d;
  logic [1:0]       edge0_q, edge0_d, edge1_q, edge1_d;
  logic             pend0_q, pend0_d, pend1_q, pend1_d;
  logic [31:0]      rd_data_q, rd_data_d;
`ifdef GPIO_PORT_SYNC_EN
  logic [WIDTH-1:0] meta_q,  meta_d;
`endif

  logic        wr_en, rd_en;
  logic [1:0]  reg_sel;
  logic [31:0] mode_img, odata_img, idata_img, cfg_img;
  logic [31:0] mode_wr, odata_wr, cfg_wr;
  logic [31:0] sync_ext, dly_ext;
  logic        sel0_ok, sel1_ok, set0, set1, clr0, clr1;
  logic        unused_addr;

  assign unused_addr = ^addr;

  function automatic logic [31:0] merge_lanes(input logic [31:0] cur,
                                              input logic [31:0] wdat,
                                              input logic [3:0]  stb);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) begin
      if (stb[b]) r[b*8 +: 8] = wdat[b*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic edge_hit(input logic [1:0] mode,
                                    input logic       cur,
                                    input logic       prev);
    return (mode[0] & cur & ~prev) | (mode[1] & ~cur & prev);
  endfunction

  assign wr_en   = en & we;
  assign rd_en   = en & ~we;
  assign reg_sel = addr[3:2];

  // Register images as seen on the bus; unimplemented bits read as zero.
  always_comb begin
    mode_img  = 32'(mode_q);
    odata_img = 32'(odata_q);
    idata_img = 32'(sync_q);
    cfg_img   = {8'd0, pend1_q, edge1_q, sel1_q, 8'd0, pend0_q, edge0_q, sel0_q};
    mode_wr   = merge_lanes(mode_img,  wr_data, wr_strobe);
    odata_wr  = merge_lanes(odata_img, wr_data, wr_strobe);
    cfg_wr    = merge_lanes(cfg_img,   wr_data, wr_strobe);
  end

  // Input path: the delayed copy is kept per pin so reselecting a channel never fakes an edge.
  always_comb begin
`ifdef GPIO_PORT_SYNC_EN
    meta_d = gpio_i;
    sync_d = meta_q;
`else
    sync_d = gpio_i;
`endif
    dly_d    = sync_q;
    sync_ext = 32'(sync_q);
    dly_ext  = 32'(dly_q);
    sel0_ok  = int'(sel0_q) < WIDTH;
    sel1_ok  = int'(sel1_q) < WIDTH;
    set0     = sel0_ok && edge_hit(edge0_q, sync_ext[sel0_q], dly_ext[sel0_q]);
    set1     = sel1_ok && edge_hit(edge1_q, sync_ext[sel1_q], dly_ext[sel1_q]);
  end

  always_comb begin
    mode_d  = mode_q;
    odata_d = odata_q;
    sel0_d  = sel0_q;
    edge0_d = edge0_q;
    sel1_d  = sel1_q;
    edge1_d = edge1_q;
    clr0    = 1'b0;
    clr1    = 1'b0;
    if (wr_en) begin
      case (reg_sel)
        REG_MODE:   mode_d  = mode_wr[WIDTH-1:0];
        REG_ODATA:  odata_d = odata_wr[WIDTH-1:0];
        REG_INTCFG: begin
          sel0_d  = cfg_wr[4:0];
          edge0_d = cfg_wr[6:5];
          sel1_d  = cfg_wr[20:16];
          edge1_d = cfg_wr[22:21];
          clr0    = wr_strobe[0] & wr_data[7];
          clr1    = wr_strobe[2] & wr_data[23];
        end
        default: ;
      endcase
    end
    // A fresh edge in the same cycle as a W1C keeps the interrupt pending.
    pend0_d = set0 | (pend0_q & ~clr0);
    pend1_d = set1 | (pend1_q & ~clr1);
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      case (reg_sel)
        REG_MODE:   rd_data_d = mode_img;
        REG_IDATA:  rd_data_d = idata_img;
        REG_ODATA:  rd_data_d = odata_img;
        REG_INTCFG: rd_data_d = cfg_img;
        default:    rd_data_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= '0;
      odata_q   <= '0;
      sync_q    <= '0;
      dly_q     <= '0;
      sel0_q    <= '0;
      edge0_q   <= '0;
      pend0_q   <= 1'b0;
      sel1_q    <= '0;
      edge1_q   <= '0;
      pend1_q   <= 1'b0;
      rd_data_q <= '0;
`ifdef GPIO_PORT_SYNC_EN
      meta_q    <= '0;
`endif
    end else begin
      mode_q    <= mode_d;
      odata_q   <= odata_d;
      sync_q    <= sync_d;
      dly_q     <= dly_d;
      sel0_q    <= sel0_d;
      edge0_q   <= edge0_d;
      pend0_q   <= pend0_d;
      sel1_q    <= sel1_d;
      edge1_q   <= edge1_d;
      pend1_q   <= pend1_d;
      rd_data_q <= rd_data_d;
`ifdef GPIO_PORT_SYNC_EN
      meta_q    <= meta_d;
`endif
    end
  end

  assign rd_data = rd_data_q;
  assign gpio_o  = odata_q;
  assign gpio_oe = mode_q;
  assign int0    = pend0_q;
  assign int1    = pend1_q;

endmodule

// File: tb/tb_gpio_port.sv
// Bench for gpio_port (WIDTH=16): register vector table plus interrupt and reset sequences.
module tb_gpio_port;

`ifdef GPIO_PORT_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strobe;
  logic [31:0] rd_data;
  logic [15:0] gpio_i;
  logic [15:0] gpio_o;
  logic [15:0] gpio_oe;
  logic        int0;
  logic        int1;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic [15:0] exp_oe;
    logic [15:0] exp_o;
  } vec_t;

  vec_t vecs[10];

  gpio_port #(.WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .we        (we),
    .addr      (addr),
    .wr_data   (wr_data),
    .wr_strobe (wr_strobe),
    .rd_data   (rd_data),
    .gpio_i    (gpio_i),
    .gpio_o    (gpio_o),
    .gpio_oe   (gpio_oe),
    .int0      (int0),
    .int1      (int1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    en = 1'b1; we = 1'b1; addr = a; wr_data = d; wr_strobe = s;
    @(negedge clk);
    en = 1'b0; we = 1'b0; wr_data = '0; wr_strobe = '0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string name);
    en = 1'b1; we = 1'b0; addr = a;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(negedge clk);
    en = 1'b0;
    check(name_q.pop_front(), rd_data, exp_q.pop_front());
  endtask

  initial begin
    vecs[0] = '{4'h8, 32'hFFFF_A5A5, 4'b0001, 32'h0000_00A5, 16'h0000, 16'h00A5};
    vecs[1] = '{4'h8, 32'h0000_3C00, 4'b0010, 32'h0000_3CA5, 16'h0000, 16'h3CA5};
    vecs[2] = '{4'h0, 32'h1234_5678, 4'b1111, 32'h0000_5678, 16'h5678, 16'h3CA5};
    vecs[3] = '{4'h0, 32'hFFFF_FFFF, 4'b0010, 32'h0000_FF78, 16'hFF78, 16'h3CA5};
    vecs[4] = '{4'h4, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, 16'hFF78, 16'h3CA5};
    vecs[5] = '{4'hC, 32'hFFFF_FF7F, 4'b1111, 32'h007F_007F, 16'hFF78, 16'h3CA5};
    vecs[6] = '{4'hC, 32'h0000_0000, 4'b0100, 32'h0000_007F, 16'hFF78, 16'h3CA5};
    vecs[7] = '{4'hC, 32'h0000_0000, 4'b0001, 32'h0000_0000, 16'hFF78, 16'h3CA5};
    vecs[8] = '{4'h0, 32'h0000_0000, 4'b0011, 32'h0000_0000, 16'h0000, 16'h3CA5};
    vecs[9] = '{4'h8, 32'h0000_0000, 4'b1111, 32'h0000_0000, 16'h0000, 16'h0000};

    rst_n = 1'b1; en = 1'b0; we = 1'b0; addr = '0; wr_data = '0; wr_strobe = '0; gpio_i = '0;
    #3 rst_n = 1'b0;
    wait_cycles(2);
    check("reset_rd_data", rd_data, 32'd0);
    check("reset_gpio_oe", 32'(gpio_oe), 32'd0);
    check("reset_gpio_o", 32'(gpio_o), 32'd0);
    check("reset_ints", {30'd0, int1, int0}, 32'd0);
    rst_n = 1'b1;
    wait_cycles(1);

    bus_read(4'h0, 32'd0, "reset_mode");
    bus_read(4'h4, 32'd0, "reset_idata");
    bus_read(4'h8, 32'd0, "reset_odata");
    bus_read(4'hC, 32'd0, "reset_intcfg");

    for (int i = 0; i < 10; i++) begin
      bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
      bus_read(vecs[i].addr, vecs[i].exp_rd, $sformatf("vec%0d_rd", i));
      check($sformatf("vec%0d_oe", i), 32'(gpio_oe), 32'(vecs[i].exp_oe));
      check($sformatf("vec%0d_o", i), 32'(gpio_o), 32'(vecs[i].exp_o));
    end

    // Input sampling.
    gpio_i = 16'hA53C;
    wait_cycles(SYNC_LAT);
    bus_read(4'h4, 32'h0000_A53C, "idata_sample");
    gpio_i = 16'h0000;
    wait_cycles(SYNC_LAT + 2);

    // Rising edge on pin 3 sets channel 0 only.
    bus_write(4'hC, 32'h0000_0023, 4'b1111);
    wait_cycles(2);
    gpio_i = 16'h0008;
    wait_cycles(SYNC_LAT);
    check("int0_not_early", 32'(int0), 32'd0);
    wait_cycles(1);
    check("int0_rise_set", 32'(int0), 32'd1);
    check("int1_idle", 32'(int1), 32'd0);
    bus_read(4'hC, 32'h0000_00A3, "intcfg_pend0");

    // Read data holds across a write.
    bus_write(4'h8, 32'h0000_1111, 4'b1111);
    check("rd_hold_on_write", rd_data, 32'h0000_00A3);

    bus_write(4'hC, 32'h0000_00A3, 4'b1111);
    check("int0_w1c", 32'(int0), 32'd0);
    gpio_i = 16'h0000;
    wait_cycles(SYNC_LAT + 3);
    check("int0_fall_ignored", 32'(int0), 32'd0);
    gpio_i = 16'h0008;
    wait_cycles(SYNC_LAT + 1);
    check("int0_rise_again", 32'(int0), 32'd1);

    // Edge arriving in the same cycle as the W1C wins.
    gpio_i = 16'h0000;
    wait_cycles(SYNC_LAT + 3);
    gpio_i = 16'h0008;
    wait_cycles(SYNC_LAT);
    bus_write(4'hC, 32'h0000_00A3, 4'b1111);
    check("int0_set_beats_clr", 32'(int0), 32'd1);

    // EDGE0=00 keeps pending, then blocks new sets once cleared.
    bus_write(4'hC, 32'h0000_0003, 4'b0001);
    check("int0_edge_off_keeps", 32'(int0), 32'd1);
    bus_write(4'hC, 32'h0000_0083, 4'b0001);
    check("int0_clr_edge_off", 32'(int0), 32'd0);
    gpio_i = 16'h0000;
    wait_cycles(SYNC_LAT + 3);
    gpio_i = 16'h0008;
    wait_cycles(SYNC_LAT + 3);
    check("int0_disabled", 32'(int0), 32'd0);

    // Reselecting a steady-high pin is not an edge.
    bus_write(4'hC, 32'h0025_0000, 4'b1111);
    wait_cycles(3);
    bus_write(4'hC, 32'h0023_0000, 4'b1111);
    wait_cycles(SYNC_LAT + 3);
    check("int1_resel_no_edge", 32'(int1), 32'd0);

    // Both channels on pin 3: ch0 rising, ch1 falling.
    bus_write(4'hC, 32'h0043_0023, 4'b1111);
    wait_cycles(2);
    gpio_i = 16'h0000;
    wait_cycles(SYNC_LAT + 1);
    check("shared_fall_int1", 32'(int1), 32'd1);
    check("shared_fall_int0", 32'(int0), 32'd0);
    gpio_i = 16'h0008;
    wait_cycles(SYNC_LAT + 1);
    check("shared_rise_int0", 32'(int0), 32'd1);
    check("shared_rise_int1", 32'(int1), 32'd1);

    // Out-of-range selects never fire.
    bus_write(4'hC, 32'h0080_0080, 4'b1111);
    check("both_cleared", {30'd0, int1, int0}, 32'd0);
    bus_write(4'hC, 32'h0074_0070, 4'b1111);
    for (int t = 0; t < 4; t++) begin
      gpio_i = (t % 2 == 0) ? 16'hFFFF : 16'h0000;
      wait_cycles(SYNC_LAT + 2);
    end
    check("oor_int1", 32'(int1), 32'd0);
    check("oor_int0", 32'(int0), 32'd0);
    bus_read(4'hC, 32'h0074_0070, "oor_intcfg");

    // Reset in the middle of a MODE write with int0 pending.
    bus_write(4'h0, 32'h0000_00FF, 4'b1111);
    bus_write(4'h8, 32'h0000_0F0F, 4'b1111);
    bus_write(4'hC, 32'h0000_0023, 4'b1111);
    wait_cycles(2);
    gpio_i = 16'h0008;
    wait_cycles(SYNC_LAT + 1);
    check("pre_reset_int0", 32'(int0), 32'd1);
    check("pre_reset_oe", 32'(gpio_oe), 32'h0000_00FF);
    en = 1'b1; we = 1'b1; addr = 4'h0; wr_data = 32'hFFFF_FFFF; wr_strobe = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_oe", 32'(gpio_oe), 32'd0);
    check("async_rst_int0", 32'(int0), 32'd0);
    check("async_rst_o", 32'(gpio_o), 32'd0);
    @(negedge clk);
    en = 1'b0; we = 1'b0; wr_data = '0; wr_strobe = '0;
    rst_n = 1'b1;
    wait_cycles(1);
    bus_read(4'h0, 32'd0, "post_rst_mode");
    bus_read(4'h8, 32'd0, "post_rst_odata");
    bus_read(4'hC, 32'd0, "post_rst_intcfg");
    check("post_rst_int0", 32'(int0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
